// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps the four {a,c} input combos of a gate and times its synchronized response
module gate_response_checker #(
    parameter logic [3:0] EXPECT  = 4'b0010,
    parameter logic [3:0] CARE    = 4'b1010,
    parameter int         CW      = 4,
    parameter int         TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dut_w,
    output logic          drv_a,
    output logic          drv_c,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [3:0]    fail_vec,
    output logic [CW-1:0] max_lat
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, NEXT, DONE} state_t;
    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          s;
    logic          flush;
    logic [1:0]    combo;
    logic          care;
    logic          hit;
    logic          expired;
    assign combo   = idx[1:0];
    assign care    = CARE[combo];
    assign hit     = s == EXPECT[combo];
    assign expired = cnt == CW'(TIMEOUT);
    // two-flop synchronizer; s is the only value ever compared
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= dut_w;
            s     <= sync1;
        end
    end
    // sweep controller: apply combo, let the synchronizer flush, then wait for a match or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            flush    <= 1'b0;
            drv_a    <= 1'b0;
            drv_c    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= '0;
            max_lat  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state          <= APPLY;
                    idx            <= '0;
                    cnt            <= '0;
                    flush          <= 1'b0;
                    {drv_a, drv_c} <= 2'b00;
                    busy           <= 1'b1;
                    pass           <= 1'b0;
                    fail_vec       <= '0;
                    max_lat        <= '0;
                end
                APPLY: begin
                    flush <= 1'b1;
                    cnt   <= '0;
                    if (flush) state <= WAIT;
                end
                WAIT: begin
                    if (!care) begin
                        state <= NEXT;
                    end else if (hit) begin
                        if (cnt > max_lat) max_lat <= cnt;
                        state <= NEXT;
                    end else if (expired) begin
                        fail_vec[combo] <= 1'b1;
                        state           <= NEXT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (idx == 3'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= fail_vec == '0;
                    end else begin
                        idx            <= idx + 3'd1;
                        {drv_a, drv_c} <= combo + 2'd1;
                        cnt            <= '0;
                        flush          <= 1'b0;
                        state          <= APPLY;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed sweeps against a sweep-level model of the checker
module tb_gate_response_checker;
    localparam logic [3:0] EXPECT  = 4'b0010;
    localparam logic [3:0] CARE    = 4'b1010;
    localparam int         TIMEOUT = 15;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic dut_w, drv_a, drv_c, busy, done, pass;
    logic [3:0] fail_vec, max_lat;
    int tests = 0, fails = 0, done_cnt = 0, mode = 0, cyc;
    bit chk_en = 1'b0;
    logic [2:0] dly = '0;
    logic h0, h1;
    logic m_a, m_c, m_busy, m_done, m_pass;
    logic [3:0] m_fail, m_lat;

    gate_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .dut_w(dut_w),
        .drv_a(drv_a), .drv_c(drv_c), .busy(busy), .done(done),
        .pass(pass), .fail_vec(fail_vec), .max_lat(max_lat)
    );

    always #5 clk = ~clk;

    function automatic logic gate(input logic a, input logic c);
        return {a, c} == 2'b01;
    endfunction

    always @(posedge clk) dly <= {dly[1:0], gate(drv_a, drv_c)};
    assign dut_w = mode == 0 ? gate(drv_a, drv_c) : mode == 1 ? dly[2] : mode == 2;

    always @(posedge clk) begin
        h1 <= h0;
        h0 <= dut_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_a = 0; m_c = 0; m_busy = 0; m_done = 0; m_pass = 0; m_fail = '0; m_lat = '0;
    endtask

    task automatic step(output bit ab);
        @(posedge clk);
        ab = rst;
        if (ab) mreset();
    endtask

    task automatic sweep();
        bit ab;
        int k;
        m_busy = 1; m_done = 0; m_pass = 0; m_fail = '0; m_lat = '0;
        for (int i = 0; i < 4; i++) begin
            {m_a, m_c} = 2'(i);
            step(ab); if (ab) return;
            step(ab); if (ab) return;
            k = 0;
            forever begin
                step(ab); if (ab) return;
                if (!CARE[i]) break;
                if (h1 == EXPECT[i]) begin
                    if (k > m_lat) m_lat = 4'(k);
                    break;
                end
                if (k == TIMEOUT) begin
                    m_fail[i] = 1'b1;
                    break;
                end
                k++;
            end
            step(ab); if (ab) return;
        end
        m_done = 1;
        m_pass = m_fail == 0;
        step(ab); if (ab) return;
        m_busy = 0;
        m_done = 0;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk);
            if (rst) mreset();
            else if (start) sweep();
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("drv_a", drv_a, m_a);
        check("drv_c", drv_c, m_c);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("pass", pass, m_pass);
        check("fail_vec", fail_vec, m_fail);
        check("max_lat", max_lat, m_lat);
        if (done) done_cnt++;
    end

    task automatic run(input int md, input int hold, output int c);
        mode = md;
        @(negedge clk);
        start = 1;
        repeat (hold) @(negedge clk);
        start = 0;
        c = hold - 1;
        while (done !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL sweep_timeout: done never seen after %0d cycles", c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_busy", busy, 0);
        check("rst_drv", {drv_a, drv_c}, 0);
        check("rst_fail_vec", fail_vec, 0);
        check("rst_max_lat", max_lat, 0);
        rst = 0;
        run(0, 1, cyc);
        check("zd_cycles", cyc, 16);
        check("zd_pass", pass, 1);
        check("zd_fail_vec", fail_vec, 4'b0000);
        check("zd_max_lat", max_lat, 0);
        check("zd_last_drv", {drv_a, drv_c}, 2'b11);
        @(negedge clk);
        check("zd_busy_after", busy, 0);
        run(1, 1, cyc);
        check("d3_cycles", cyc, 19);
        check("d3_pass", pass, 1);
        check("d3_max_lat", max_lat, 3);
        @(negedge clk);
        check("d3_busy_after", busy, 0);
        run(2, 1, cyc);
        check("s1_cycles", cyc, 31);
        check("s1_fail_vec", fail_vec, 4'b1000);
        check("s1_pass", pass, 0);
        check("s1_max_lat", max_lat, 0);
        repeat (2) @(negedge clk);
        run(3, 1, cyc);
        check("s0_cycles", cyc, 31);
        check("s0_fail_vec", fail_vec, 4'b0010);
        check("s0_pass", pass, 0);
        repeat (2) @(negedge clk);
        mode = 3;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        check("mid_drv_before_rst", {drv_a, drv_c}, 2'b01);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_outputs", {drv_a, drv_c, busy, done, pass, fail_vec, max_lat}, 0);
        run(0, 1, cyc);
        check("post_rst_cycles", cyc, 16);
        check("post_rst_pass", pass, 1);
        repeat (2) @(negedge clk);
        done_cnt = 0;
        run(0, 5, cyc);
        check("hold_cycles", cyc, 16);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        check("hold_done_pulses", done_cnt, 1);
        check("hold_busy_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
